// File: rtl/load_store_unit.sv
// Load/store unit for a word-wide memory: byte/half/word loads with sign/zero extension, byte/half stores by read-modify-write.
// Load latency 2 cycles, word store 2, sub-word store 3. Only one request is accepted at a time. Optional macro LSU_MISALIGN_CHECK_EN rejects misaligned half/word requests.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misal_q, misal_d;

    logic        accept;
    logic        req_misaligned;
    logic        we_raw;
    logic        is_word;
    logic        is_half;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign accept = (state_q == IDLE) && req_valid;

`ifdef LSU_MISALIGN_CHECK_EN
    // Size 11 behaves as a word, so size[1] alone identifies word accesses.
    assign req_misaligned = req_size[1] ? (req_addr[1:0] != 2'b00)
                                        : (req_size[0] & req_addr[0]);
`else
    assign req_misaligned = 1'b0;
`endif

    assign is_word = size_q[1];
    assign is_half = (size_q == 2'b01);

    always_comb begin
        byte_sel = mem_read_data[7:0];
        case (addr_q[1:0])
            2'b00: byte_sel = mem_read_data[7:0];
            2'b01: byte_sel = mem_read_data[15:8];
            2'b10: byte_sel = mem_read_data[23:16];
            2'b11: byte_sel = mem_read_data[31:24];
            default: byte_sel = mem_read_data[7:0];
        endcase
    end

    assign half_sel = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];

    always_comb begin
        load_val = mem_read_data;
        if (is_half) begin
            load_val = {{16{~unsigned_q & half_sel[15]}}, half_sel};
        end else if (!is_word) begin
            load_val = {{24{~unsigned_q & byte_sel[7]}}, byte_sel};
        end
    end

    // Sub-word store: replace only the addressed lane(s) of the word just read.
    always_comb begin
        merged = mem_read_data;
        if (is_half) begin
            if (addr_q[1]) merged = {wdata_q[15:0], mem_read_data[15:0]};
            else           merged = {mem_read_data[31:16], wdata_q[15:0]};
        end else begin
            case (addr_q[1:0])
                2'b00: merged = {mem_read_data[31:8], wdata_q[7:0]};
                2'b01: merged = {mem_read_data[31:16], wdata_q[7:0], mem_read_data[7:0]};
                2'b10: merged = {mem_read_data[31:24], wdata_q[7:0], mem_read_data[15:0]};
                2'b11: merged = {wdata_q[7:0], mem_read_data[23:0]};
                default: merged = mem_read_data;
            endcase
        end
    end

    always_comb begin
        state_d        = state_q;
        rdata_d        = rdata_q;
        merge_d        = merge_q;
        misal_d        = misal_q;
        mem_address    = 32'd0;
        mem_write_data = 32'd0;
        we_raw         = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    misal_d = req_misaligned;
                    state_d = req_misaligned ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_address = {addr_q[31:2], 2'b00};
                state_d     = RESP;
                if (!write_q) begin
                    rdata_d = load_val;
                end else if (is_word) begin
                    we_raw         = 1'b1;
                    mem_write_data = wdata_q;
                end else begin
                    merge_d = merged;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                mem_address    = {addr_q[31:2], 2'b00};
                mem_write_data = merge_q;
                we_raw         = 1'b1;
                state_d        = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            merge_q    <= 32'd0;
            rdata_q    <= 32'd0;
            misal_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            misal_q <= misal_d;
            if (accept) begin
                write_q    <= req_write;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
            end
        end
    end

    // Reset gates the write strobe immediately so an interrupted RMW never lands.
    assign mem_write_enable = we_raw & ~rst;
    assign req_ready        = (state_q == IDLE) & ~rst;
    assign resp_valid       = (state_q == RESP);
    assign resp_misaligned  = resp_valid & misal_q;
    assign resp_rdata       = rdata_q;

endmodule
